// File: rtl/pong_match_ctrl_if.sv
// Signal bundle between the Pong match sequencer and its surroundings.
// slave is the controller side; master is the button/miss/paddle/ball side.
interface pong_match_ctrl_if;
    logic       frame_tick_i;
    logic       start_btn_i;
    logic       p1_up_btn_i;
    logic       p1_down_btn_i;
    logic       p2_up_btn_i;
    logic       p2_down_btn_i;
    logic       miss_left_i;
    logic       miss_right_i;

    logic       paddle_reset_o;
    logic       ball_reset_o;
    logic       ball_run_o;
    logic       p1_up_o;
    logic       p1_down_o;
    logic       p2_up_o;
    logic       p2_down_o;
    logic [3:0] score_l_o;
    logic [3:0] score_r_o;
    logic [2:0] state_o;
    logic [1:0] winner_o;

    modport slave (
        input  frame_tick_i, start_btn_i,
        input  p1_up_btn_i, p1_down_btn_i, p2_up_btn_i, p2_down_btn_i,
        input  miss_left_i, miss_right_i,
        output paddle_reset_o, ball_reset_o, ball_run_o,
        output p1_up_o, p1_down_o, p2_up_o, p2_down_o,
        output score_l_o, score_r_o, state_o, winner_o
    );

    modport master (
        output frame_tick_i, start_btn_i,
        output p1_up_btn_i, p1_down_btn_i, p2_up_btn_i, p2_down_btn_i,
        output miss_left_i, miss_right_i,
        input  paddle_reset_o, ball_reset_o, ball_run_o,
        input  p1_up_o, p1_down_o, p2_up_o, p2_down_o,
        input  score_l_o, score_r_o, state_o, winner_o
    );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: game FSM, scores, paddle/ball controls and
// frame-paced paddle move strobes. Every output is a register.
//
//  state | meaning
//  IDLE  | waiting for start, paddles and ball held in reset
//  SERVE | ball centred, paddles movable, counting serve frames
//  PLAY  | ball running, misses score points
//  POINT | pause after a point, counting point frames
//  OVER  | winner decided, waiting for start
module pong_match_ctrl #(
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 30,
    parameter int unsigned MOVE_STEPS   = 2
) (
    input  logic              clock_i,
    input  logic              reset_i,
    pong_match_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);
    localparam logic [7:0] POINT_LOAD = 8'(POINT_FRAMES);
    localparam logic [3:0] STEP_LOAD  = 4'(MOVE_STEPS);
    localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       start_prev_q;
    logic [3:0] score_l_q, score_l_d;
    logic [3:0] score_r_q, score_r_d;
    logic [1:0] winner_q, winner_d;
    logic       paddle_reset_q, paddle_reset_d;
    logic       ball_reset_q, ball_reset_d;
    logic       ball_run_q, ball_run_d;
    logic [3:0] p1_step_q, p1_step_d;
    logic [3:0] p2_step_q, p2_step_d;
    logic [1:0] p1_dir_q, p1_dir_d;
    logic [1:0] p2_dir_q, p2_dir_d;
    logic       p1_up_q, p1_up_d, p1_down_q, p1_down_d;
    logic       p2_up_q, p2_up_d, p2_down_q, p2_down_d;

    logic       start_edge;
    logic       move_en;
    logic       tick_act;
    logic [3:0] score_l_inc;
    logic [3:0] score_r_inc;

    // Direction as {up, down}; conflicting or absent presses give no move.
    function automatic logic [1:0] dir_of(input logic up, input logic dn);
        return {up & ~dn, dn & ~up};
    endfunction

    assign start_edge  = bus.start_btn_i & ~start_prev_q;
    assign score_l_inc = score_l_q + 4'd1;
    assign score_r_inc = score_r_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        winner_d  = winner_q;

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    cnt_d     = SERVE_LOAD;
                    state_d   = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (bus.frame_tick_i) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        cnt_d   = 8'd0;
                        state_d = ST_PLAY;
                    end
                end
            end
            ST_PLAY: begin
                if (bus.miss_left_i && bus.miss_right_i) begin
                    cnt_d   = SERVE_LOAD;
                    state_d = ST_SERVE;
                end else if (bus.miss_left_i) begin
                    score_r_d = score_r_inc;
                    if (score_r_inc == WIN_VAL) begin
                        winner_d = 2'b10;
                        state_d  = ST_OVER;
                    end else begin
                        cnt_d   = POINT_LOAD;
                        state_d = ST_POINT;
                    end
                end else if (bus.miss_right_i) begin
                    score_l_d = score_l_inc;
                    if (score_l_inc == WIN_VAL) begin
                        winner_d = 2'b01;
                        state_d  = ST_OVER;
                    end else begin
                        cnt_d   = POINT_LOAD;
                        state_d = ST_POINT;
                    end
                end
            end
            ST_POINT: begin
                if (bus.frame_tick_i) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        cnt_d   = SERVE_LOAD;
                        state_d = ST_SERVE;
                    end
                end
            end
            ST_OVER: begin
                if (start_edge) begin
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    winner_d  = 2'b00;
                    cnt_d     = SERVE_LOAD;
                    state_d   = ST_SERVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        paddle_reset_d = (state_d == ST_IDLE);
        ball_run_d     = (state_d == ST_PLAY);
        ball_reset_d   = ~ball_run_d;
    end

    // Bursts follow the next state so they are already off in the first
    // cycle of POINT/OVER/IDLE.
    assign move_en  = (state_d == ST_SERVE) || (state_d == ST_PLAY);
    assign tick_act = bus.frame_tick_i &&
                      ((state_q == ST_SERVE) || (state_q == ST_PLAY));

    always_comb begin
        p1_step_d = p1_step_q;
        p1_dir_d  = p1_dir_q;
        if (!move_en) begin
            p1_step_d = 4'd0;
            p1_dir_d  = 2'b00;
        end else if (tick_act) begin
            p1_dir_d  = dir_of(bus.p1_up_btn_i, bus.p1_down_btn_i);
            p1_step_d = (p1_dir_d != 2'b00) ? STEP_LOAD : 4'd0;
        end else if (p1_step_q != 4'd0) begin
            p1_step_d = p1_step_q - 4'd1;
        end
        p1_up_d   = p1_dir_d[1] && (p1_step_d != 4'd0);
        p1_down_d = p1_dir_d[0] && (p1_step_d != 4'd0);
    end

    always_comb begin
        p2_step_d = p2_step_q;
        p2_dir_d  = p2_dir_q;
        if (!move_en) begin
            p2_step_d = 4'd0;
            p2_dir_d  = 2'b00;
        end else if (tick_act) begin
            p2_dir_d  = dir_of(bus.p2_up_btn_i, bus.p2_down_btn_i);
            p2_step_d = (p2_dir_d != 2'b00) ? STEP_LOAD : 4'd0;
        end else if (p2_step_q != 4'd0) begin
            p2_step_d = p2_step_q - 4'd1;
        end
        p2_up_d   = p2_dir_d[1] && (p2_step_d != 4'd0);
        p2_down_d = p2_dir_d[0] && (p2_step_d != 4'd0);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 8'd0;
            start_prev_q   <= 1'b0;
            score_l_q      <= 4'd0;
            score_r_q      <= 4'd0;
            winner_q       <= 2'b00;
            paddle_reset_q <= 1'b1;
            ball_reset_q   <= 1'b1;
            ball_run_q     <= 1'b0;
            p1_step_q      <= 4'd0;
            p2_step_q      <= 4'd0;
            p1_dir_q       <= 2'b00;
            p2_dir_q       <= 2'b00;
            p1_up_q        <= 1'b0;
            p1_down_q      <= 1'b0;
            p2_up_q        <= 1'b0;
            p2_down_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            start_prev_q   <= bus.start_btn_i;
            score_l_q      <= score_l_d;
            score_r_q      <= score_r_d;
            winner_q       <= winner_d;
            paddle_reset_q <= paddle_reset_d;
            ball_reset_q   <= ball_reset_d;
            ball_run_q     <= ball_run_d;
            p1_step_q      <= p1_step_d;
            p2_step_q      <= p2_step_d;
            p1_dir_q       <= p1_dir_d;
            p2_dir_q       <= p2_dir_d;
            p1_up_q        <= p1_up_d;
            p1_down_q      <= p1_down_d;
            p2_up_q        <= p2_up_d;
            p2_down_q      <= p2_down_d;
        end
    end

    assign bus.state_o        = state_q;
    assign bus.score_l_o      = score_l_q;
    assign bus.score_r_o      = score_r_q;
    assign bus.winner_o       = winner_q;
    assign bus.paddle_reset_o = paddle_reset_q;
    assign bus.ball_reset_o   = ball_reset_q;
    assign bus.ball_run_o     = ball_run_q;
    assign bus.p1_up_o        = p1_up_q;
    assign bus.p1_down_o      = p1_down_q;
    assign bus.p2_up_o        = p2_up_q;
    assign bus.p2_down_o      = p2_down_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed stimulus pushes expected output
// changes (value and cycle) into a queue; a monitor checks every change.
module tb_pong_match_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pong_match_ctrl_if bus ();

    pong_match_ctrl dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    typedef struct {
        logic [19:0] vec;
        int          cyc;
    } exp_t;

    exp_t        expq[$];
    logic [3:0]  sl_m = 4'd0;
    logic [3:0]  sr_m = 4'd0;
    logic [1:0]  win_m = 2'b00;
    logic [19:0] cur;
    logic [19:0] prev;

    // Expected output vector for a given state and strobe set, using the
    // bench's own score/winner model.
    function automatic logic [19:0] mk(input int st, input logic u1, input logic d1,
                                       input logic u2, input logic d2);
        logic pr, br, run;
        pr  = (st == 0);
        run = (st == 2);
        br  = !run;
        return {3'(st), sl_m, sr_m, win_m, pr, br, run, u1, d1, u2, d2};
    endfunction

    task automatic push(input logic [19:0] v, input int off);
        exp_t e;
        e.vec = v;
        e.cyc = cyc + off;
        expq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            cur = {bus.state_o, bus.score_l_o, bus.score_r_o, bus.winner_o,
                   bus.paddle_reset_o, bus.ball_reset_o, bus.ball_run_o,
                   bus.p1_up_o, bus.p1_down_o, bus.p2_up_o, bus.p2_down_o};
            if (cur !== prev) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change cyc=%0d got=%h", cyc, cur);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    if (e.vec !== cur || e.cyc != cyc) begin
                        failures++;
                        $display("FAIL out_change cyc=%0d got=%h required=%h at cyc=%0d",
                                 cyc, cur, e.vec, e.cyc);
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic tick();
        bus.frame_tick_i = 1'b1;
        @(negedge clk);
        bus.frame_tick_i = 1'b0;
        bus.miss_left_i  = 1'b0;
        bus.miss_right_i = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic serve_to_play();
        for (int k = 1; k <= 60; k++) begin
            if (k == 10) begin
                bus.miss_left_i  = 1'b1;
                bus.miss_right_i = 1'b1;
            end
            if (k == 60) push(mk(2, 0, 0, 0, 0), 1);
            tick();
        end
    endtask

    task automatic point_to_serve();
        for (int k = 1; k <= 30; k++) begin
            if (k == 5) bus.miss_left_i = 1'b1;
            if (k == 30) push(mk(1, 0, 0, 0, 0), 1);
            tick();
        end
    endtask

    task automatic score(input logic left);
        if (left) begin
            bus.miss_right_i = 1'b1;
            sl_m = sl_m + 4'd1;
        end else begin
            bus.miss_left_i = 1'b1;
            sr_m = sr_m + 4'd1;
        end
        if (sl_m == 4'd7) win_m = 2'b01;
        else if (sr_m == 4'd7) win_m = 2'b10;
        if (win_m != 2'b00) push(mk(4, 0, 0, 0, 0), 1);
        else push(mk(3, 0, 0, 0, 0), 1);
        @(negedge clk);
        bus.miss_left_i  = 1'b0;
        bus.miss_right_i = 1'b0;
        if (win_m == 2'b00) begin
            point_to_serve();
            serve_to_play();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d pending=%0d", cyc, expq.size());
        $fatal(1);
    end

    initial begin
        bus.frame_tick_i  = 1'b0;
        bus.start_btn_i   = 1'b0;
        bus.p1_up_btn_i   = 1'b0;
        bus.p1_down_btn_i = 1'b0;
        bus.p2_up_btn_i   = 1'b0;
        bus.p2_down_btn_i = 1'b0;
        bus.miss_left_i   = 1'b0;
        bus.miss_right_i  = 1'b0;
        push(mk(0, 0, 0, 0, 0), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // start held high well over 100 cycles: a single IDLE->SERVE
        bus.start_btn_i = 1'b1;
        push(mk(1, 0, 0, 0, 0), 1);
        @(negedge clk);
        for (int k = 1; k <= 60; k++) begin
            if (k == 26) bus.start_btn_i = 1'b0;
            if (k == 60) push(mk(2, 0, 0, 0, 0), 1);
            tick();
        end

        // p1 up burst of 2 cycles; mid-burst button change ignored
        bus.p1_up_btn_i = 1'b1;
        push(mk(2, 1, 0, 0, 0), 1);
        push(mk(2, 0, 0, 0, 0), 3);
        bus.frame_tick_i = 1'b1;
        @(negedge clk);
        bus.frame_tick_i  = 1'b0;
        bus.p1_up_btn_i   = 1'b0;
        bus.p1_down_btn_i = 1'b1;
        repeat (3) @(negedge clk);
        bus.p1_down_btn_i = 1'b0;

        // both directions pressed: no strobe
        bus.p1_up_btn_i   = 1'b1;
        bus.p1_down_btn_i = 1'b1;
        tick();
        bus.p1_up_btn_i   = 1'b0;
        bus.p1_down_btn_i = 1'b0;

        bus.p2_down_btn_i = 1'b1;
        push(mk(2, 0, 0, 0, 1), 1);
        push(mk(2, 0, 0, 0, 0), 3);
        tick();
        bus.p2_down_btn_i = 1'b0;

        // back-to-back ticks restart the burst: 3 cycles high
        bus.p1_up_btn_i = 1'b1;
        push(mk(2, 1, 0, 0, 0), 1);
        push(mk(2, 0, 0, 0, 0), 4);
        bus.frame_tick_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.frame_tick_i = 1'b0;
        repeat (3) @(negedge clk);
        bus.p1_up_btn_i = 1'b0;

        bus.p1_down_btn_i = 1'b1;
        bus.p2_up_btn_i   = 1'b1;
        push(mk(2, 0, 1, 1, 0), 1);
        push(mk(2, 0, 0, 0, 0), 3);
        tick();
        bus.p1_down_btn_i = 1'b0;
        bus.p2_up_btn_i   = 1'b0;

        // start edge ignored in PLAY
        bus.start_btn_i = 1'b1;
        @(negedge clk);
        bus.start_btn_i = 1'b0;
        @(negedge clk);

        score(1'b1);
        score(1'b0);

        // simultaneous misses: no score, back to SERVE
        bus.miss_left_i  = 1'b1;
        bus.miss_right_i = 1'b1;
        push(mk(1, 0, 0, 0, 0), 1);
        @(negedge clk);
        bus.miss_left_i  = 1'b0;
        bus.miss_right_i = 1'b0;
        serve_to_play();

        // burst aborted on the cycle POINT is entered
        bus.p2_up_btn_i = 1'b1;
        push(mk(2, 0, 0, 1, 0), 1);
        bus.frame_tick_i = 1'b1;
        @(negedge clk);
        bus.frame_tick_i = 1'b0;
        bus.p2_up_btn_i  = 1'b0;
        score(1'b1);

        for (int i = 0; i < 5; i++) score(1'b1);

        // OVER: misses, ticks and buttons ignored
        bus.miss_right_i = 1'b1;
        @(negedge clk);
        bus.miss_right_i = 1'b0;
        bus.miss_left_i  = 1'b1;
        @(negedge clk);
        bus.miss_left_i  = 1'b0;
        bus.p1_up_btn_i  = 1'b1;
        tick();
        bus.p1_up_btn_i  = 1'b0;

        sl_m  = 4'd0;
        sr_m  = 4'd0;
        win_m = 2'b00;
        bus.start_btn_i = 1'b1;
        push(mk(1, 0, 0, 0, 0), 1);
        @(negedge clk);
        bus.start_btn_i = 1'b0;
        @(negedge clk);
        serve_to_play();

        score(1'b1);
        score(1'b1);
        score(1'b0);
        score(1'b0);
        score(1'b1);

        // reset mid-PLAY at 3-2 with a burst running
        bus.p1_up_btn_i = 1'b1;
        push(mk(2, 1, 0, 0, 0), 1);
        bus.frame_tick_i = 1'b1;
        @(negedge clk);
        bus.frame_tick_i = 1'b0;
        rst  = 1'b1;
        sl_m = 4'd0;
        sr_m = 4'd0;
        push(mk(0, 0, 0, 0, 0), 1);
        @(negedge clk);
        rst = 1'b0;
        bus.p1_up_btn_i = 1'b0;
        repeat (5) @(negedge clk);

        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL pending_expected got=%0d required=0 next_cyc=%0d",
                     expq.size(), expq[0].cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Match sequencer for the Pong datapath: owns the game state machine, scores, and the reset/run controls of the paddles and ball.
- Converts raw player buttons into rate-limited up/down strobes for the two paddle instances, paced by the frame tick.
- Sits between the button inputs / ball miss detectors and the paddle and ball position blocks.

Parameters:
- WIN_SCORE, 7, points needed to win; legal range 1..15.
- SERVE_FRAMES, 60, frame ticks spent in SERVE before the ball is released; legal range 1..255.
- POINT_FRAMES, 30, frame ticks of pause after a point; legal range 1..255.
- MOVE_STEPS, 2, consecutive 1-clock move strobes issued per frame tick; legal range 1..15; must be less than the clocks between ticks.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame
- start_btn  in  1  level; only its rising edge is used
- p1_up_btn, p1_down_btn  in  1 each  left player buttons (levels)
- p2_up_btn, p2_down_btn  in  1 each  right player buttons (levels)
- miss_left  in  1  pulse: ball passed the left paddle
- miss_right  in  1  pulse: ball passed the right paddle
- paddle_reset  out  1  drives reset of both paddles
- ball_reset  out  1  holds ball at centre
- ball_run  out  1  ball motion enable
- p1_up, p1_down, p2_up, p2_down  out  1 each  move strobes to the paddles
- score_l, score_r  out  4 each  player scores
- state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4
- winner  out  2  00 none, 01 left, 10 right

Behaviour:
- All outputs are registered; each responds one clock after the causing input.
- Reset, from any state: state=IDLE, scores=0, winner=00, paddle_reset=1, ball_reset=1, ball_run=0, all strobes 0, counters 0, start edge register cleared.
- start edge: start_btn=1 this cycle and 0 the previous cycle.
- IDLE:
  - paddle_reset=1, ball_reset=1.
  - On start edge: scores cleared, frame counter loaded with SERVE_FRAMES, go to SERVE.
- SERVE:
  - paddle_reset=0, ball_reset=1, ball_run=0; paddles movable.
  - Each frame_tick decrements the counter. The tick that takes it 1->0 moves to PLAY.
  - Net effect: PLAY entered on the clock after the SERVE_FRAMES-th tick.
- PLAY:
  - ball_reset=0, ball_run=1.
  - miss_left alone: score_r+1. miss_right alone: score_l+1.
  - Both misses in the same cycle: no score change, reload SERVE_FRAMES, go to SERVE.
  - After a score: if the new score equals WIN_SCORE, go to OVER and set winner; otherwise load POINT_FRAMES and go to POINT.
- POINT:
  - ball_run=0, ball_reset=1, no movement.
  - Counts POINT_FRAMES ticks (same rule as SERVE), then reloads SERVE_FRAMES and goes to SERVE.
  - Miss inputs are ignored.
- OVER:
  - ball_run=0, ball_reset=1, no movement; scores and winner held.
  - On start edge: scores=0, winner=00, reload SERVE_FRAMES, go to SERVE.
- Miss inputs are ignored outside PLAY; start edges are ignored outside IDLE and OVER.
- Move strobes:
  - Active only in SERVE and PLAY.
  - On frame_tick, each player's direction is sampled: up only -> up; down only -> down; both or neither -> none.
  - A per-player step counter is loaded with MOVE_STEPS. The chosen strobe is high for exactly MOVE_STEPS consecutive cycles, starting the cycle after the tick.
  - Button changes mid-burst have no effect.
  - A tick arriving while a burst is still running restarts the burst.
  - Leaving SERVE/PLAY aborts bursts: strobes are 0 from the first cycle in the new state.
  - Up and down strobes for one player are never high together.
- Scores saturate by construction: the game stops at WIN_SCORE and the counters never wrap.

Test Plan:
- Reset mid-PLAY with score 3-2 -> next cycle state=0, scores 0/0, paddle_reset=1, ball_run=0, strobes 0.
- start_btn held high for 100 cycles in IDLE -> exactly one transition to SERVE; state=2 one cycle after the 60th frame_tick.
- PLAY, p1_up_btn=1 at a frame_tick, MOVE_STEPS=2 -> p1_up high for exactly 2 cycles after the tick; p1_up and p1_down both pressed -> no strobe.
- PLAY, miss_right pulse -> score_l 0->1, state=POINT; after 30 ticks state=SERVE; miss_left and miss_right in the same cycle -> scores unchanged, state=SERVE.
- Left player reaches 7 -> state=OVER, winner=01, further misses ignored; a start edge -> scores 0/0, winner=00, state=SERVE.
- Strobe burst in progress when a point is scored -> strobes drop to 0 on the cycle state becomes POINT.
